// File: rtl/mpeg_mv_pkg.sv
// rtl/mpeg_mv_pkg.sv - shared motion-vector types, widths and range helper
package mpeg_mv_pkg;

  localparam int MV_CODE_W = 6;
  localparam int MV_RES_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT_X = 2'd1,
    EMIT_Y = 2'd2
  } mv_state_e;

  // Half-width of the legal difference/vector range for a given r_size.
  function automatic logic signed [31:0] mv_lim(input int r_size);
    return 32'sd16 <<< r_size;
  endfunction

endpackage

// File: rtl/mv_component_encode.sv
// rtl/mv_component_encode.sv - one-component motion code/residual encoder
module mv_component_encode
  import mpeg_mv_pkg::*;
#(
  parameter int R_SIZE = 2
) (
  input  logic signed [31:0]          v_i,
  input  logic signed [31:0]          p_i,
  output logic signed [MV_CODE_W-1:0] code_o,
  output logic        [MV_RES_W-1:0]  residual_o,
  output logic signed [31:0]          recon_o,
  output logic                        range_err_o
);

  localparam logic signed [31:0] LIM    = mv_lim(R_SIZE);
  localparam logic        [31:0] F_MASK = (32'd1 << R_SIZE) - 32'd1;

  logic signed [31:0] raw;
  logic signed [31:0] d;
  logic signed [31:0] mag;
  logic signed [31:0] code_full;
  logic        [31:0] res_full;
  logic signed [31:0] rsum;

  always_comb begin
    raw = v_i - p_i;
    d   = raw;
    if (raw < -LIM) begin
      d = raw + (LIM <<< 1);
    end else if (raw >= LIM) begin
      d = raw - (LIM <<< 1);
    end

    mag       = (d < 0) ? (-d - 32'sd1) : (d - 32'sd1);
    code_full = (mag >>> R_SIZE) + 32'sd1;
    res_full  = mag & F_MASK;
    if (d == 0) begin
      code_full = '0;
      res_full  = '0;
    end else if (d < 0) begin
      code_full = -code_full;
    end

    // Reconstruction mirrors the decoder so both predictors track exactly.
    rsum = p_i + d;
    if (rsum < -LIM) begin
      rsum = rsum + (LIM <<< 1);
    end else if (rsum >= LIM) begin
      rsum = rsum - (LIM <<< 1);
    end

    range_err_o = (v_i < -LIM) || (v_i >= LIM);
  end

  assign code_o     = MV_CODE_W'(code_full);
  assign residual_o = MV_RES_W'(res_full);
  assign recon_o    = rsum;

endmodule

// File: rtl/encode_motion_vector.sv
// rtl/encode_motion_vector.sv - motion vector encoder emitting x then y code/residual pairs
module encode_motion_vector
  import mpeg_mv_pkg::*;
#(
  parameter int R_SIZE = 2,
  parameter int VW     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [VW-1:0]        mv_x,
  input  logic signed [VW-1:0]        mv_y,
  input  logic                        full_pel_vector,
  input  logic                        pmv_clear,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_comp,
  output logic signed [MV_CODE_W-1:0] motion_code,
  output logic        [MV_RES_W-1:0]  motion_residual,
  output logic                        range_err
);

  if ((R_SIZE < 0) || (R_SIZE > 8)) begin : g_bad_r_size
    $error("encode_motion_vector: R_SIZE must be 0..8");
  end

  mv_state_e                   state_q, state_d;
  logic signed [VW-1:0]        mv_y_q, mv_y_d;
  logic                        fp_q, fp_d;
  logic signed [VW-1:0]        pmv_x_q, pmv_x_d;
  logic signed [VW-1:0]        pmv_y_q, pmv_y_d;
  logic signed [VW-1:0]        recon_x_q, recon_x_d;
  logic signed [VW-1:0]        recon_y_q, recon_y_d;
  logic signed [MV_CODE_W-1:0] code_q, code_d;
  logic        [MV_RES_W-1:0]  res_q, res_d;
  logic                        comp_q, comp_d;
  logic                        err_q, err_d;

  logic                        sel_fp;
  logic signed [VW-1:0]        sel_mv;
  logic signed [VW-1:0]        sel_p;
  logic signed [31:0]          enc_v, enc_p, enc_recon, recon_sh;
  logic signed [MV_CODE_W-1:0] enc_code;
  logic        [MV_RES_W-1:0]  enc_res;
  logic                        enc_err;
  logic signed [VW-1:0]        pmv_new;

  // One encoder: x operands while idle (capture cycle), y operands otherwise.
  always_comb begin
    if (state_q == IDLE) begin
      sel_fp = full_pel_vector;
      sel_mv = mv_x;
      sel_p  = pmv_clear ? '0 : pmv_x_q;
    end else begin
      sel_fp = fp_q;
      sel_mv = mv_y_q;
      sel_p  = pmv_y_q;
    end
    enc_v    = sel_fp ? (32'(sel_mv) >>> 1) : 32'(sel_mv);
    enc_p    = sel_fp ? (32'(sel_p) >>> 1) : 32'(sel_p);
    recon_sh = sel_fp ? (enc_recon <<< 1) : enc_recon;
    pmv_new  = VW'(recon_sh);
  end

  mv_component_encode #(.R_SIZE(R_SIZE)) u_enc (
    .v_i        (enc_v),
    .p_i        (enc_p),
    .code_o     (enc_code),
    .residual_o (enc_res),
    .recon_o    (enc_recon),
    .range_err_o(enc_err)
  );

  always_comb begin
    state_d   = state_q;
    mv_y_d    = mv_y_q;
    fp_d      = fp_q;
    pmv_x_d   = pmv_x_q;
    pmv_y_d   = pmv_y_q;
    recon_x_d = recon_x_q;
    recon_y_d = recon_y_q;
    code_d    = code_q;
    res_d     = res_q;
    comp_d    = comp_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (pmv_clear) begin
          pmv_x_d = '0;
          pmv_y_d = '0;
        end
        if (in_valid) begin
          mv_y_d    = mv_y;
          fp_d      = full_pel_vector;
          code_d    = enc_code;
          res_d     = enc_res;
          err_d     = enc_err;
          comp_d    = 1'b0;
          recon_x_d = pmv_new;
          state_d   = EMIT_X;
        end
      end
      EMIT_X: begin
        if (out_ready) begin
          code_d    = enc_code;
          res_d     = enc_res;
          err_d     = enc_err;
          comp_d    = 1'b1;
          recon_y_d = pmv_new;
          state_d   = EMIT_Y;
        end
      end
      EMIT_Y: begin
        if (out_ready) begin
          pmv_x_d = recon_x_q;
          pmv_y_d = recon_y_q;
          code_d  = '0;
          res_d   = '0;
          err_d   = 1'b0;
          comp_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mv_y_q    <= '0;
      fp_q      <= 1'b0;
      pmv_x_q   <= '0;
      pmv_y_q   <= '0;
      recon_x_q <= '0;
      recon_y_q <= '0;
      code_q    <= '0;
      res_q     <= '0;
      comp_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mv_y_q    <= mv_y_d;
      fp_q      <= fp_d;
      pmv_x_q   <= pmv_x_d;
      pmv_y_q   <= pmv_y_d;
      recon_x_q <= recon_x_d;
      recon_y_q <= recon_y_d;
      code_q    <= code_d;
      res_q     <= res_d;
      comp_q    <= comp_d;
      err_q     <= err_d;
    end
  end

  assign in_ready        = (state_q == IDLE);
  assign out_valid       = (state_q != IDLE);
  assign out_comp        = comp_q;
  assign motion_code     = code_q;
  assign motion_residual = res_q;
  assign range_err       = err_q;

endmodule
